quad_step_decoder: RTL

Upstream stage for the 4-bit up/down counter: converts a two-channel quadrature encoder (A/B) into a registered direction level (`up_down`) and a one-cycle `step` strobe. The counter's `up_down` input is fed from this block. The counter is qualified so that it advances only on `step`. Asynchronous encoder pins are synchronised and glitch-filtered here. Illegal double transitions are flagged and counted.

---
 rtl/quad_step_decoder.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/quad_step_decoder.sv
// quad_step_decoder
//   Turns a two-channel quadrature encoder into a registered direction level and a
//   one-cycle step strobe for a downstream up/down counter. Each pin is synchronised
//   and run-length filtered. Double transitions are flagged and counted.
//
// Ports
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-low reset
//   enc_a    in   encoder channel A (asynchronous)
//   enc_b    in   encoder channel B (asynchronous)
//   clr      in   synchronous clear of err_cnt
//   step     out  one-cycle pulse per legal transition
//   up_down  out  direction of last legal transition (1 = up), held between steps
//   err      out  one-cycle pulse per illegal (double) transition
//   err_cnt  out  saturating count of illegal transitions
module quad_step_decoder #(
  parameter int unsigned FILT_LEN = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enc_a,
  input  logic       enc_b,
  input  logic       clr,
  output logic       step,
  output logic       up_down,
  output logic       err,
  output logic [7:0] err_cnt
);

  localparam logic [3:0] FiltLast = 4'(FILT_LEN - 1);
  localparam logic [4:0] GuardEnd = 5'(FILT_LEN + 3);

  logic       s1_a_q, s2_a_q, s1_b_q, s2_b_q;
  logic       filt_a_q, filt_a_d, filt_b_q, filt_b_d;
  logic [3:0] run_a_q, run_a_d, run_b_q, run_b_d;
  logic [1:0] cur, prev_q;
  logic [4:0] guard_q, guard_d;
  logic       step_q, step_d, up_q, up_d, err_q, err_d;
  logic [7:0] cnt_q, cnt_d;

  assign cur = {filt_a_q, filt_b_q};

  // Run-length filters: the filtered level moves only after the synchronised pin has
  // disagreed with it for FILT_LEN consecutive cycles.
  always_comb begin
    filt_a_d = filt_a_q;
    run_a_d  = run_a_q;
    if (s2_a_q == filt_a_q) begin
      run_a_d = '0;
    end else if (run_a_q == FiltLast) begin
      filt_a_d = s2_a_q;
      run_a_d  = '0;
    end else begin
      run_a_d = run_a_q + 4'd1;
    end
  end

  always_comb begin
    filt_b_d = filt_b_q;
    run_b_d  = run_b_q;
    if (s2_b_q == filt_b_q) begin
      run_b_d = '0;
    end else if (run_b_q == FiltLast) begin
      filt_b_d = s2_b_q;
      run_b_d  = '0;
    end else begin
      run_b_d = run_b_q + 4'd1;
    end
  end

  // Transition decode. Gray-code steps change one bit; for those, direction is
  // prev[1] ^ cur[0] (forward 00->01->11->10->00 gives 1). Both bits changing is
  // illegal. Strobes are suppressed until the start-up guard has expired so a pin
  // resting away from 00 at power-up does not look like a transition.
  always_comb begin
    step_d  = 1'b0;
    err_d   = 1'b0;
    up_d    = up_q;
    cnt_d   = cnt_q;
    guard_d = guard_q;
    if (guard_q < GuardEnd) begin
      guard_d = guard_q + 5'd1;
    end else begin
      case (prev_q ^ cur)
        2'b00:   ;
        2'b11:   err_d = 1'b1;
        default: begin
          step_d = 1'b1;
          up_d   = prev_q[1] ^ cur[0];
        end
      endcase
    end
    if (err_d && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end
    // Clear takes priority over a same-cycle increment.
    if (clr) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_a_q   <= 1'b0;
      s2_a_q   <= 1'b0;
      s1_b_q   <= 1'b0;
      s2_b_q   <= 1'b0;
      filt_a_q <= 1'b0;
      filt_b_q <= 1'b0;
      run_a_q  <= '0;
      run_b_q  <= '0;
      prev_q   <= '0;
      guard_q  <= '0;
      step_q   <= 1'b0;
      up_q     <= 1'b1;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s1_a_q   <= enc_a;
      s2_a_q   <= s1_a_q;
      s1_b_q   <= enc_b;
      s2_b_q   <= s1_b_q;
      filt_a_q <= filt_a_d;
      filt_b_q <= filt_b_d;
      run_a_q  <= run_a_d;
      run_b_q  <= run_b_d;
      prev_q   <= cur;
      guard_q  <= guard_d;
      step_q   <= step_d;
      up_q     <= up_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign step    = step_q;
  assign up_down = up_q;
  assign err     = err_q;
  assign err_cnt = cnt_q;

endmodule
